// File: rtl/multi_channel_scoreboard.sv
`default_nettype none
// ============================================================================
// multi_channel_scoreboard: per-channel FIFO occupancy plus one tagged word
// tracked through a run-time selected channel.            Rev 1.0
// ============================================================================
module multi_channel_scoreboard #(
  parameter int NUM_CH    = 4,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int CHECK_LAT = 0,
  parameter int MAX_WAIT  = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [$clog2(NUM_CH)-1:0] sel,
  input  logic [NUM_CH-1:0]         push,
  input  logic [NUM_CH-1:0]         pop,
  input  logic [NUM_CH*WIDTH-1:0]   flat_data_in,
  input  logic [WIDTH-1:0]          data_out,
  output logic                      data_out_vld,
  output logic                      busy,
  output logic                      done,
  output logic [2:0]                err,
  output logic                      prop_signal
);

  localparam int SW = $clog2(NUM_CH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [WW-1:0] WAIT_LIM = WW'(MAX_WAIT);
  localparam bit            LAT_EN   = (CHECK_LAT != 0);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [1:0] FAIL  = 2'd3;

  logic [1:0]        state;
  logic [CW-1:0]     cnt      [NUM_CH];
  logic [CW-1:0]     cnt_nxt  [NUM_CH];
  logic [WIDTH-1:0]  data_ch  [NUM_CH];
  logic [NUM_CH-1:0] occ_fault;
  logic [CW-1:0]     ahead;
  logic [CW-1:0]     ahead_init;
  logic [WW-1:0]     wait_cnt;
  logic [WIDTH-1:0]  data_q;
  logic [SW-1:0]     sel_q;
  logic [CW-1:0]     sel_cnt;
  logic              capture;
  logic              trk_pop;
  logic              timeout;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_nxt[i]   = cnt[i];
      occ_fault[i] = 1'b0;
      data_ch[i]   = flat_data_in[i*WIDTH +: WIDTH];
      case ({push[i], pop[i]})
        // Simultaneous push/pop on an empty FIFO: the pop underflows, the push lands.
        2'b11: if (cnt[i] == '0) begin
          cnt_nxt[i]   = CW'(1);
          occ_fault[i] = 1'b1;
        end
        2'b10: if (cnt[i] < DEPTH_C) cnt_nxt[i] = cnt[i] + CW'(1);
               else occ_fault[i] = 1'b1;
        2'b01: if (cnt[i] != '0) cnt_nxt[i] = cnt[i] - CW'(1);
               else occ_fault[i] = 1'b1;
        default: ;
      endcase
    end
  end

  assign sel_cnt    = cnt[sel];
  assign capture    = (state == IDLE) && start && push[sel] &&
                      ((sel_cnt < DEPTH_C) || pop[sel]);
  assign ahead_init = (sel_cnt == '0) ? '0 : (sel_cnt - CW'(pop[sel]));
  assign trk_pop    = (state == ARMED) && pop[sel_q];
  assign timeout    = LAT_EN && (wait_cnt == WAIT_LIM);

  assign data_out_vld = trk_pop && (ahead == '0);
  assign busy         = (state == ARMED);
  assign prop_signal  = ~|err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ahead    <= '0;
      wait_cnt <= '0;
      data_q   <= '0;
      sel_q    <= '0;
      done     <= 1'b0;
      err      <= 3'b000;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= cnt_nxt[i];
      if (|occ_fault) err[1] <= 1'b1;

      case (state)
        IDLE: begin
          if (capture) begin
            data_q   <= data_ch[sel];
            sel_q    <= sel;
            ahead    <= ahead_init;
            wait_cnt <= '0;
            state    <= ARMED;
          end
        end
        ARMED: begin
          if (wait_cnt != '1) wait_cnt <= wait_cnt + WW'(1);
          // A tracked pop takes priority over a timeout in the same cycle.
          if (trk_pop) begin
            if (ahead != '0) begin
              ahead <= ahead - CW'(1);
            end else if (data_out == data_q) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state  <= FAIL;
              err[0] <= 1'b1;
            end
          end else if (timeout) begin
            state  <= FAIL;
            err[2] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_scoreboard.sv
`default_nettype none
// ============================================================================
// tb_multi_channel_scoreboard: directed checks on a default instance and a
// latency-checking instance driven from the same stimulus.   Rev 1.0
// ============================================================================
module tb_multi_channel_scoreboard;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  sel;
  logic [3:0]  push;
  logic [3:0]  pop;
  logic [31:0] flat_data_in;
  logic [7:0]  data_out;

  logic       data_out_vld, busy, done, prop_signal;
  logic [2:0] err;
  logic       vld_l, busy_l, done_l, prop_l;
  logic [2:0] err_l;

  logic v, vl;
  int errors = 0;
  int checks = 0;

  multi_channel_scoreboard #(
    .NUM_CH(4), .WIDTH(8), .DEPTH(4), .CHECK_LAT(0), .MAX_WAIT(64)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel), .push(push), .pop(pop),
    .flat_data_in(flat_data_in), .data_out(data_out),
    .data_out_vld(data_out_vld), .busy(busy), .done(done), .err(err),
    .prop_signal(prop_signal)
  );

  multi_channel_scoreboard #(
    .NUM_CH(4), .WIDTH(8), .DEPTH(4), .CHECK_LAT(1), .MAX_WAIT(8)
  ) dut_lat (
    .clk(clk), .rst(rst), .start(start), .sel(sel), .push(push), .pop(pop),
    .flat_data_in(flat_data_in), .data_out(data_out),
    .data_out_vld(vld_l), .busy(busy_l), .done(done_l), .err(err_l),
    .prop_signal(prop_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset;
    rst = 1'b0; start = 1'b0; sel = 2'd0; push = 4'd0; pop = 4'd0;
    flat_data_in = 32'd0; data_out = 8'd0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // Drive one cycle of inputs, sample the combinational strobes, then clock.
  task automatic step(input logic s, input logic [1:0] sl, input logic [3:0] ps,
                      input logic [3:0] pp, input logic [31:0] fd,
                      input logic [7:0] dout, output logic ov, output logic ovl);
    start = s; sel = sl; push = ps; pop = pp; flat_data_in = fd; data_out = dout;
    #1;
    ov  = data_out_vld;
    ovl = vld_l;
    @(posedge clk); #1;
    start = 1'b0; push = 4'd0; pop = 4'd0;
  endtask

  task automatic test_reset;
    apply_reset;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL reset_err: got %b want 000", err); end
    checks++; if (prop_signal !== 1'b1) begin errors++; $display("FAIL reset_prop: got %b want 1", prop_signal); end
    checks++; if (data_out_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", data_out_vld); end
  endtask

  task automatic test_track_match;
    apply_reset;
    step(0, 2'd2, 4'b0100, 4'b0000, 32'h0, 8'h0, v, vl);
    step(0, 2'd2, 4'b0100, 4'b0000, 32'h0, 8'h0, v, vl);
    step(1, 2'd2, 4'b0100, 4'b0000, 32'h33A52211, 8'h0, v, vl);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL match_armed: got %b want 1", busy); end
    // start/sel/push on another channel while armed must not retarget.
    step(1, 2'd1, 4'b0010, 4'b0100, 32'h00009900, 8'hA5, v, vl);
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL match_pop1_vld: got %b want 0", v); end
    step(0, 2'd0, 4'b0000, 4'b0100, 32'h0, 8'hA5, v, vl);
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL match_pop2_vld: got %b want 0", v); end
    step(0, 2'd0, 4'b0000, 4'b0100, 32'h0, 8'hA5, v, vl);
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL match_pop3_vld: got %b want 1", v); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL match_done: got %b want 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL match_busy: got %b want 0", busy); end
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL match_err: got %b want 000", err); end
    checks++; if (prop_signal !== 1'b1) begin errors++; $display("FAIL match_prop: got %b want 1", prop_signal); end
  endtask

  task automatic test_track_mismatch;
    apply_reset;
    step(0, 2'd2, 4'b0100, 4'b0000, 32'h0, 8'h0, v, vl);
    step(0, 2'd2, 4'b0100, 4'b0000, 32'h0, 8'h0, v, vl);
    step(1, 2'd2, 4'b0100, 4'b0000, 32'h33A52211, 8'h0, v, vl);
    step(0, 2'd0, 4'b0000, 4'b0100, 32'h0, 8'h5A, v, vl);
    step(0, 2'd0, 4'b0000, 4'b0100, 32'h0, 8'h5A, v, vl);
    step(0, 2'd0, 4'b0000, 4'b0100, 32'h0, 8'h5A, v, vl);
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL mism_vld: got %b want 1", v); end
    checks++; if (err !== 3'b001) begin errors++; $display("FAIL mism_err: got %b want 001", err); end
    checks++; if (prop_signal !== 1'b0) begin errors++; $display("FAIL mism_prop: got %b want 0", prop_signal); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mism_done: got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mism_busy: got %b want 0", busy); end
  endtask

  task automatic test_overflow;
    apply_reset;
    for (int k = 0; k < 4; k++) step(0, 2'd0, 4'b0010, 4'b0000, 32'h0, 8'h0, v, vl);
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL ovf_fill_err: got %b want 000", err); end
    step(0, 2'd0, 4'b0010, 4'b0000, 32'h0, 8'h0, v, vl);
    checks++; if (err !== 3'b010) begin errors++; $display("FAIL ovf_err: got %b want 010", err); end
    checks++; if (prop_signal !== 1'b0) begin errors++; $display("FAIL ovf_prop: got %b want 0", prop_signal); end
    // Count must still be 4: a push+pop capture on a full channel leaves 3 ahead.
    step(1, 2'd1, 4'b0010, 4'b0010, 32'h00007700, 8'h0, v, vl);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovf_cap_busy: got %b want 1", busy); end
    for (int k = 0; k < 3; k++) begin
      step(0, 2'd0, 4'b0000, 4'b0010, 32'h0, 8'h77, v, vl);
      checks++; if (v !== 1'b0) begin errors++; $display("FAIL ovf_early_vld%0d: got %b want 0", k, v); end
    end
    step(0, 2'd0, 4'b0000, 4'b0010, 32'h0, 8'h77, v, vl);
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL ovf_tracked_vld: got %b want 1", v); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ovf_done: got %b want 1", done); end
    checks++; if (err !== 3'b010) begin errors++; $display("FAIL ovf_err_final: got %b want 010", err); end
  endtask

  task automatic test_underflow;
    apply_reset;
    step(0, 2'd0, 4'b0000, 4'b1000, 32'h0, 8'h0, v, vl);
    checks++; if (err !== 3'b010) begin errors++; $display("FAIL udf_err: got %b want 010", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL udf_busy: got %b want 0", busy); end
  endtask

  task automatic test_same_cycle;
    apply_reset;
    step(1, 2'd0, 4'b0001, 4'b0001, 32'h0000003C, 8'h0, v, vl);
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL same_cap_vld: got %b want 0", v); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL same_busy: got %b want 1", busy); end
    checks++; if (err !== 3'b010) begin errors++; $display("FAIL same_err: got %b want 010", err); end
    step(0, 2'd0, 4'b0000, 4'b0110, 32'h0, 8'h3C, v, vl);
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL same_other_vld: got %b want 0", v); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL same_other_busy: got %b want 1", busy); end
    step(0, 2'd0, 4'b0000, 4'b0001, 32'h0, 8'h3C, v, vl);
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL same_pop_vld: got %b want 1", v); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL same_done: got %b want 1", done); end
  endtask

  task automatic test_latency;
    apply_reset;
    step(1, 2'd3, 4'b1000, 4'b0000, 32'hC3000000, 8'h0, v, vl);
    for (int k = 0; k < 8; k++) step(0, 2'd0, 4'b0000, 4'b0000, 32'h0, 8'h0, v, vl);
    checks++; if (busy_l !== 1'b1) begin errors++; $display("FAIL lat_pre_busy: got %b want 1", busy_l); end
    checks++; if (err_l !== 3'b000) begin errors++; $display("FAIL lat_pre_err: got %b want 000", err_l); end
    step(0, 2'd0, 4'b0000, 4'b0000, 32'h0, 8'h0, v, vl);
    checks++; if (err_l !== 3'b100) begin errors++; $display("FAIL lat_to_err: got %b want 100", err_l); end
    checks++; if (prop_l !== 1'b0) begin errors++; $display("FAIL lat_to_prop: got %b want 0", prop_l); end
    checks++; if (busy_l !== 1'b0) begin errors++; $display("FAIL lat_to_busy: got %b want 0", busy_l); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nolat_busy: got %b want 1", busy); end
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL nolat_err: got %b want 000", err); end

    apply_reset;
    step(1, 2'd3, 4'b1000, 4'b0000, 32'hC3000000, 8'h0, v, vl);
    for (int k = 0; k < 8; k++) step(0, 2'd0, 4'b0000, 4'b0000, 32'h0, 8'h0, v, vl);
    step(0, 2'd0, 4'b0000, 4'b1000, 32'h0, 8'hC3, v, vl);
    checks++; if (vl !== 1'b1) begin errors++; $display("FAIL lat_edge_vld: got %b want 1", vl); end
    checks++; if (done_l !== 1'b1) begin errors++; $display("FAIL lat_edge_done: got %b want 1", done_l); end
    checks++; if (err_l !== 3'b000) begin errors++; $display("FAIL lat_edge_err: got %b want 000", err_l); end
  endtask

  task automatic test_async_reset;
    apply_reset;
    step(0, 2'd0, 4'b0000, 4'b1000, 32'h0, 8'h0, v, vl);
    step(0, 2'd0, 4'b0001, 4'b0000, 32'h0, 8'h0, v, vl);
    step(1, 2'd0, 4'b0001, 4'b0000, 32'h0000005E, 8'h0, v, vl);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arst_pre_busy: got %b want 1", busy); end
    rst = 1'b0;
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", busy); end
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL arst_err: got %b want 000", err); end
    checks++; if (prop_signal !== 1'b1) begin errors++; $display("FAIL arst_prop: got %b want 1", prop_signal); end
    #2;
    rst = 1'b1;
    // Counters were cleared, so the fresh capture sits at the head.
    step(1, 2'd0, 4'b0001, 4'b0000, 32'h000000E7, 8'h0, v, vl);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arst_recap_busy: got %b want 1", busy); end
    step(0, 2'd0, 4'b0000, 4'b0001, 32'h0, 8'hE7, v, vl);
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL arst_recap_vld: got %b want 1", v); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL arst_recap_done: got %b want 1", done); end
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL arst_recap_err: got %b want 000", err); end
  endtask

  initial begin
    test_reset;
    test_track_match;
    test_track_mismatch;
    test_overflow;
    test_underflow;
    test_same_cycle;
    test_latency;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
